// File: rtl/bnn_ocr_pkg.sv
// Shared constants and types for the SPI image receive path.
// Holds command bytes, frame size and the receiver state encoding.
package bnn_ocr_pkg;

    localparam int         IMG_BYTES = 113;
    localparam logic [7:0] CMD_IMAGE = 8'hA5;
    localparam logic [7:0] CMD_CLEAR = 8'hC3;

    typedef enum logic [1:0] {
        IDLE    = 2'd0,
        CMD     = 2'd1,
        DATA    = 2'd2,
        DISCARD = 2'd3
    } rx_state_t;

endpackage

// File: rtl/byte_fifo.sv
// Small synchronous byte FIFO with first-word-fall-through head output.
// A push into a full FIFO is accepted only when a pop happens in the same cycle.
module byte_fifo #(
    parameter int DEPTH = 4
) (
    input  logic                       clk,
    input  logic                       rst_n,
    input  logic                       i_push,
    input  logic                       i_pop,
    input  logic                       i_flush,
    input  logic [7:0]                 i_data,
    output logic [7:0]                 o_head,
    output logic                       o_full,
    output logic                       o_empty,
    output logic [$clog2(DEPTH):0]     o_count
);

    localparam int             AW       = $clog2(DEPTH);
    localparam logic [AW:0]    FULL_CNT = (AW+1)'(DEPTH);

    logic [7:0]    r_mem [DEPTH];
    logic [AW-1:0] r_wr_ptr;
    logic [AW-1:0] r_rd_ptr;
    logic [AW:0]   r_count;
    logic          w_push;
    logic          w_pop;

    assign o_full  = (r_count == FULL_CNT);
    assign o_empty = (r_count == '0);
    assign o_count = r_count;
    assign o_head  = o_empty ? 8'h00 : r_mem[r_rd_ptr];

    assign w_pop  = i_pop && !o_empty;
    assign w_push = i_push && (!o_full || w_pop);

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_wr_ptr <= '0;
            r_rd_ptr <= '0;
            r_count  <= '0;
        end else if (i_flush) begin
            r_wr_ptr <= '0;
            r_rd_ptr <= '0;
            r_count  <= '0;
        end else begin
            if (w_push) r_wr_ptr <= r_wr_ptr + 1'b1;
            if (w_pop)  r_rd_ptr <= r_rd_ptr + 1'b1;
            case ({w_push, w_pop})
                2'b10:   r_count <= r_count + 1'b1;
                2'b01:   r_count <= r_count - 1'b1;
                default: r_count <= r_count;
            endcase
        end
    end

    always_ff @(posedge clk) begin
        if (w_push && !i_flush) r_mem[r_wr_ptr] <= i_data;
    end

endmodule

// File: rtl/spi_image_rx.sv
// SPI mode-0 slave that receives a command byte followed by an image payload
// and streams payload bytes through a small FIFO to a downstream buffer.
module spi_image_rx
    import bnn_ocr_pkg::*;
#(
    parameter int FIFO_DEPTH = 4,
    parameter int IMG_BYTES  = bnn_ocr_pkg::IMG_BYTES
) (
    input  logic       clk,
    input  logic       rst_n,
    input  logic       spi_sclk,
    input  logic       spi_mosi,
    input  logic       spi_cs_n,
    input  logic       write_ready,
    output logic [7:0] data_out,
    output logic       write_request,
    output logic       clear_buffer,
    output logic       frame_done,
    output logic       overflow,
    output logic       busy
);

    localparam int          FAW       = $clog2(FIFO_DEPTH);
    localparam logic [6:0]  LAST_CNT  = 7'(IMG_BYTES - 1);
    localparam logic [6:0]  FULL_CNT  = 7'(IMG_BYTES);
    localparam logic [FAW:0] ONE_ENTRY = (FAW+1)'(1);

    logic [1:0]  r_sclk_sync;
    logic [1:0]  r_mosi_sync;
    logic [1:0]  r_cs_sync;
    logic        r_sclk_d;
    logic        r_cs_d;
    logic        r_mosi_d;
    logic        r_cs_low;
    logic        r_sclk_rise;
    logic        r_cs_fall;
    logic        r_cs_rise;

    logic [7:0]  r_shift;
    logic [2:0]  r_bit_cnt;
    logic        r_byte_vld;

    rx_state_t   r_state;
    rx_state_t   w_state_nxt;
    logic        w_cmd_image;
    logic        w_cmd_clear;
    logic        w_data_byte;

    logic [6:0]  r_payload_cnt;
    logic        r_overflow;
    logic        r_clear_buffer;
    logic        r_frame_done;
    logic        r_done_sent;

    logic        w_fifo_full;
    logic        w_fifo_empty;
    logic [FAW:0] w_fifo_count;
    logic [7:0]  w_head;
    logic        w_pop;
    logic        w_push;
    logic        w_drop;
    logic        w_fifo_done;

    // Synchronizers plus registered edge pulses; mosi is delayed to stay aligned.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_sclk_sync <= 2'b00;
            r_mosi_sync <= 2'b00;
            r_cs_sync   <= 2'b11;
            r_sclk_d    <= 1'b0;
            r_cs_d      <= 1'b1;
            r_mosi_d    <= 1'b0;
            r_cs_low    <= 1'b0;
            r_sclk_rise <= 1'b0;
            r_cs_fall   <= 1'b0;
            r_cs_rise   <= 1'b0;
        end else begin
            r_sclk_sync <= {r_sclk_sync[0], spi_sclk};
            r_mosi_sync <= {r_mosi_sync[0], spi_mosi};
            r_cs_sync   <= {r_cs_sync[0], spi_cs_n};
            r_sclk_d    <= r_sclk_sync[1];
            r_cs_d      <= r_cs_sync[1];
            r_mosi_d    <= r_mosi_sync[1];
            r_cs_low    <= !r_cs_sync[1];
            r_sclk_rise <= r_sclk_sync[1] && !r_sclk_d;
            r_cs_fall   <= r_cs_d && !r_cs_sync[1];
            r_cs_rise   <= !r_cs_d && r_cs_sync[1];
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_bit_cnt  <= 3'd0;
            r_byte_vld <= 1'b0;
        end else begin
            r_byte_vld <= 1'b0;
            if (r_cs_fall || r_cs_rise) begin
                r_bit_cnt <= 3'd0;
            end else if (r_sclk_rise && r_cs_low) begin
                r_bit_cnt  <= r_bit_cnt + 3'd1;
                r_byte_vld <= (r_bit_cnt == 3'd7);
            end
        end
    end

    always_ff @(posedge clk) begin
        if (r_sclk_rise && r_cs_low) r_shift <= {r_shift[6:0], r_mosi_d};
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) r_state <= IDLE;
        else        r_state <= w_state_nxt;
    end

    always_comb begin
        w_state_nxt = r_state;
        w_cmd_image = 1'b0;
        w_cmd_clear = 1'b0;
        w_data_byte = 1'b0;
        if (r_cs_rise) begin
            w_state_nxt = IDLE;
        end else begin
            case (r_state)
                IDLE: if (r_cs_fall) w_state_nxt = CMD;
                CMD: begin
                    if (r_byte_vld) begin
                        w_state_nxt = DISCARD;
                        if (r_shift == CMD_IMAGE) begin
                            w_cmd_image = 1'b1;
                            w_state_nxt = DATA;
                        end else if (r_shift == CMD_CLEAR) begin
                            w_cmd_clear = 1'b1;
                        end
                    end
                end
                DATA: begin
                    if (r_byte_vld) begin
                        w_data_byte = 1'b1;
                        if (r_payload_cnt == LAST_CNT) w_state_nxt = DISCARD;
                    end
                end
                DISCARD: w_state_nxt = DISCARD;
                default: w_state_nxt = IDLE;
            endcase
        end
    end

    assign w_pop  = !w_fifo_empty && write_ready;
    assign w_push = w_data_byte && (!w_fifo_full || w_pop);
    assign w_drop = w_data_byte && w_fifo_full && !w_pop;

    // The transfer that drains the last byte of a fully counted frame.
    assign w_fifo_done = w_pop && !w_push && !w_cmd_clear &&
                         (w_fifo_count == ONE_ENTRY) &&
                         (r_payload_cnt == FULL_CNT) && !r_done_sent;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_payload_cnt  <= 7'd0;
            r_overflow     <= 1'b0;
            r_clear_buffer <= 1'b0;
            r_frame_done   <= 1'b0;
            r_done_sent    <= 1'b0;
        end else begin
            r_clear_buffer <= w_cmd_image || w_cmd_clear;
            r_frame_done   <= 1'b0;
            if (w_cmd_image) begin
                r_payload_cnt <= 7'd0;
                r_overflow    <= 1'b0;
                r_done_sent   <= 1'b0;
            end else begin
                if (w_cmd_clear) r_overflow    <= 1'b0;
                if (w_data_byte) r_payload_cnt <= r_payload_cnt + 7'd1;
                if (w_drop)      r_overflow    <= 1'b1;
                if (w_fifo_done) begin
                    r_frame_done <= 1'b1;
                    r_done_sent  <= 1'b1;
                end
            end
        end
    end

    byte_fifo #(
        .DEPTH (FIFO_DEPTH)
    ) u_fifo (
        .clk     (clk),
        .rst_n   (rst_n),
        .i_push  (w_push),
        .i_pop   (w_pop),
        .i_flush (w_cmd_clear),
        .i_data  (r_shift),
        .o_head  (w_head),
        .o_full  (w_fifo_full),
        .o_empty (w_fifo_empty),
        .o_count (w_fifo_count)
    );

    assign data_out      = w_head;
    assign write_request = !w_fifo_empty;
    assign clear_buffer  = r_clear_buffer;
    assign frame_done    = r_frame_done;
    assign overflow      = r_overflow;
    assign busy          = (r_state != IDLE) || !w_fifo_empty;

endmodule
